// File: rtl/disp_chan_sched.sv
// Round-robin arbiter for display channel 0 plus the channel-select scanner.
// Optional macro SCHED_SNAP_EN: a grant in auto mode snaps Test to channel 0.
module disp_chan_sched #(
  parameter int unsigned DWELL = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         auto_en,
  input  logic [2:0]   man_sel,
  input  logic [7:0]   chan_mask,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  input  logic [31:0]  req_les,
  input  logic [31:0]  req_point,
  output logic [3:0]   gnt,
  output logic         EN,
  output logic [31:0]  Data0,
  output logic [7:0]   les0,
  output logic [7:0]   point0,
  output logic [2:0]   Test,
  output logic         busy
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        en_q, en_d;
  logic [31:0] data0_q, data0_d;
  logic [7:0]  les0_q, les0_d;
  logic [7:0]  point0_q, point0_d;
  logic [2:0]  test_q, test_d;
  logic [31:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic        grant_fire;
  logic [1:0]  win;
  logic        dwell_done;

  // First requester found walking upward from ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] w;
    logic [1:0] idx;
    w = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // Next enabled channel above cur (cur itself last); 0 when nothing is enabled.
  function automatic logic [2:0] next_chan(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] n;
    logic [2:0] idx;
    n = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) n = idx;
    end
    return n;
  endfunction

  assign grant_fire = (state_q == IDLE) && (|req);
  assign win        = rr_pick(req, rr_q);
  assign dwell_done = (cnt_q == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    en_d     = 1'b0;
    rr_d     = rr_q;
    data0_d  = data0_q;
    les0_d   = les0_q;
    point0_d = point0_q;
    busy_d   = (state_d != IDLE);
    if (grant_fire) begin
      gnt_d    = 4'b0001 << win;
      en_d     = 1'b1;
      rr_d     = win + 2'd1;
      data0_d  = req_data[{win, 5'd0} +: 32];
      les0_d   = req_les[{win, 3'd0} +: 8];
      point0_d = req_point[{win, 3'd0} +: 8];
    end
  end

  // Channel select: manual follows man_sel, auto walks the enabled mask.
  always_comb begin
    test_d = test_q;
    cnt_d  = cnt_q;
    if (!auto_en) begin
      test_d = man_sel;
      cnt_d  = '0;
    end else if (dwell_done) begin
      test_d = next_chan(test_q, chan_mask);
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + 32'd1;
    end
`ifdef SCHED_SNAP_EN
    if (auto_en && grant_fire) begin
      test_d = 3'd0;
      cnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= 2'd0;
      gnt_q    <= 4'd0;
      en_q     <= 1'b0;
      data0_q  <= 32'h0000_0000;
      les0_q   <= 8'hFF;
      point0_q <= 8'h00;
      test_q   <= 3'd0;
      cnt_q    <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      data0_q  <= data0_d;
      les0_q   <= les0_d;
      point0_q <= point0_d;
      test_q   <= test_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign EN     = en_q;
  assign Data0  = data0_q;
  assign les0   = les0_q;
  assign point0 = point0_q;
  assign Test   = test_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_disp_chan_sched.sv
// Scoreboard bench for disp_chan_sched: a deadline-based reference model queues
// expected outputs per edge; a monitor pops and compares them on the falling edge.
module tb_disp_chan_sched;

  localparam int unsigned DW = 4;

  logic         clk;
  logic         rst;
  logic         auto_en;
  logic [2:0]   man_sel;
  logic [7:0]   chan_mask;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [31:0]  req_les;
  logic [31:0]  req_point;
  logic [3:0]   gnt;
  logic         EN;
  logic [31:0]  Data0;
  logic [7:0]   les0;
  logic [7:0]   point0;
  logic [2:0]   Test;
  logic         busy;

  disp_chan_sched #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .man_sel(man_sel),
    .chan_mask(chan_mask), .req(req), .req_data(req_data), .req_les(req_les),
    .req_point(req_point), .gnt(gnt), .EN(EN), .Data0(Data0), .les0(les0),
    .point0(point0), .Test(Test), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint      e;
    logic [3:0]  g;
    logic        en;
    logic [31:0] d;
    logic [7:0]  l;
    logic [7:0]  p;
    logic [2:0]  t;
    logic        b;
  } exp_t;

  exp_t tq[$];
  exp_t gq[$];
  int   n_total = 0;
  int   n_pass  = 0;
  longint cyc = 0;

  function automatic logic [2:0] nxt(input int cur, input logic [7:0] m);
    for (int i = 1; i <= 8; i++)
      if (m[(cur + i) % 8]) return 3'((cur + i) % 8);
    return 3'd0;
  endfunction

  // Reference model: grants allowed from an absolute edge onward, channel
  // advances at absolute deadline edges.
  initial begin
    int     mrr;
    longint next_ok, adv_at;
    logic [2:0]  mt;
    logic [31:0] md;
    logic [7:0]  ml, mp;
    logic [3:0]  g;
    exp_t r;
    int k;
    mrr = 0; next_ok = 0; adv_at = 0; mt = 0; md = 0; ml = 8'hFF; mp = 0;
    forever begin
      @(posedge clk);
      g = '0;
      if (rst) begin
        mrr = 0; next_ok = cyc + 1; adv_at = cyc + DW;
        mt = 0; md = 0; ml = 8'hFF; mp = 0;
      end else begin
        if (cyc >= next_ok && req != 4'd0) begin
          k = -1;
          for (int i = 0; i < 4; i++)
            if (k < 0 && req[(mrr + i) % 4]) k = (mrr + i) % 4;
          g[k] = 1'b1;
          md = req_data[32*k +: 32];
          ml = req_les[8*k +: 8];
          mp = req_point[8*k +: 8];
          mrr = (k + 1) % 4;
          next_ok = cyc + 3;
        end
        if (!auto_en) begin
          mt = man_sel;
          adv_at = cyc + DW;
        end else if (cyc == adv_at) begin
          mt = nxt(int'(mt), chan_mask);
          adv_at = cyc + DW;
        end
`ifdef SCHED_SNAP_EN
        if (auto_en && g != 4'd0) begin
          mt = 3'd0;
          adv_at = cyc + DW;
        end
`endif
      end
      r.e = cyc; r.g = g; r.en = (g != 4'd0); r.d = md; r.l = ml; r.p = mp; r.t = mt;
      r.b = !rst && (cyc < next_ok - 1);
      tq.push_back(r);
      if (g != 4'd0) gq.push_back(r);
      cyc++;
    end
  end

  // Monitor
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (tq.size() > 0) begin
        r = tq.pop_front();
        n_total++;
        if (gnt === r.g && EN === r.en && Data0 === r.d && les0 === r.l &&
            point0 === r.p && Test === r.t && busy === r.b)
          n_pass++;
        else
          $display("FAIL outputs edge %0d: got gnt=%b EN=%b Data0=%h les0=%h point0=%h Test=%0d busy=%b, want gnt=%b EN=%b Data0=%h les0=%h point0=%h Test=%0d busy=%b",
                   r.e, gnt, EN, Data0, les0, point0, Test, busy, r.g, r.en, r.d, r.l, r.p, r.t, r.b);
      end
      while (gq.size() > 0 && gq[0].e < cyc - 1) begin
        r = gq.pop_front();
        n_total++;
        $display("FAIL missed_grant edge %0d: got no EN, want gnt=%b", r.e, r.g);
      end
      if (EN === 1'b1) begin
        n_total++;
        if (gq.size() > 0 && gq[0].e == cyc - 1) begin
          r = gq.pop_front();
          if (gnt === r.g && Data0 === r.d && les0 === r.l && point0 === r.p)
            n_pass++;
          else
            $display("FAIL grant_payload: got gnt=%b Data0=%h les0=%h point0=%h, want gnt=%b Data0=%h les0=%h point0=%h",
                     gnt, Data0, les0, point0, r.g, r.d, r.l, r.p);
        end else begin
          $display("FAIL spurious_grant: got gnt=%b EN=1, want no grant", gnt);
        end
      end
    end
  end

  int rq_pct = 0;

  task automatic set_slices(input int k);
    req_data[32*k +: 32] = $urandom;
    req_les[8*k +: 8]    = 8'($urandom);
    req_point[8*k +: 8]  = 8'($urandom);
  endtask

  // One cycle of requester behaviour: drop after grant, maybe re-request.
  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (gnt[k]) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 99) < rq_pct) begin
          set_slices(k);
          req[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; auto_en = 1'b0; man_sel = 3'd0; chan_mask = 8'hFF;
    req_data = '0; req_les = '0; req_point = '0;
    for (int k = 0; k < 4; k++) set_slices(k);
    req_data[64 +: 32] = 32'hDEADBEEF;
    req = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rq_pct = 0;
    cycle(14);

    man_sel = 3'd5;
    cycle(100);

    man_sel = 3'd0;
    cycle(2);
    chan_mask = 8'b1001_0010;
    auto_en = 1'b1;
    cycle(24);
    chan_mask = 8'h00;
    cycle(10);
    chan_mask = 8'hFF;

    req = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt != 4'd0) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL grant_wait: got no gnt in 20 cycles, want a grant");
    end
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(4);

    rq_pct = 30;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) auto_en = ~auto_en;
      if ($urandom_range(0, 99) < 5) man_sel = 3'($urandom);
      if ($urandom_range(0, 99) < 3) chan_mask = 8'($urandom);
      rst = ($urandom_range(0, 99) < 1);
      cycle(1);
    end
    rst = 1'b0;
    rq_pct = 0;
    cycle(12);

    n_total++;
    if (gq.size() == 0) n_pass++;
    else $display("FAIL grant_queue_drain: got %0d pending grants, want 0", gq.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
